// File: rtl/video_mixer_ng_pkg.sv
// video_mixer_ng_pkg
// Shared types and helpers for the video_mixer_ng output mixer.
//   scanline_mode_t : brightness applied to odd lines (off, 75 %, 50 %, 25 %)
//   expand8         : widen a w-bit colour (held in the low bits) to 8 bits
//                     by MSB-first bit replication
//   sl_scale        : apply a scanline brightness mode to an 8-bit channel
package video_mixer_ng_pkg;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_75  = 2'd1,
    SL_50  = 2'd2,
    SL_25  = 2'd3
  } scanline_mode_t;

  // Output bit 7-i takes input bit (w-1 - i mod w): the value is repeated
  // from its MSB downwards until 8 bits are filled.
  function automatic logic [7:0] expand8(input logic [7:0] v, input int unsigned w);
    logic [7:0] e;
    e = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      e[3'(7 - i)] = v[3'(w - 1 - (i % w))];
    end
    return e;
  endfunction

  function automatic logic [7:0] sl_scale(input logic [7:0] c, input scanline_mode_t m);
    logic [7:0] s;
    case (m)
      SL_75:   s = c - {2'b00, c[7:2]};
      SL_50:   s = {1'b0, c[7:1]};
      SL_25:   s = {2'b00, c[7:2]};
      default: s = c;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/video_mixer_ng_measure.sv
// vmix_measure
// Active-area measurement on the registered output timing.
//   CLK_VIDEO, reset : clock, synchronous active-high reset
//   ce, de, vs       : output pixel enable, data enable and vsync
//   hact             : last non-zero active pixel count per line (saturating)
//   vact             : active lines counted in the last frame (saturating)
//   meas_valid       : hact/vact come from a complete frame and are non-zero
module vmix_measure
  import video_mixer_ng_pkg::*;
#(
  parameter int unsigned HCNT_W = 12,
  parameter int unsigned VCNT_W = 11
) (
  input  logic              CLK_VIDEO,
  input  logic              reset,
  input  logic              ce,
  input  logic              de,
  input  logic              vs,
  output logic [HCNT_W-1:0] hact,
  output logic [VCNT_W-1:0] vact,
  output logic              meas_valid
);

  logic              de_d, vs_d, seen_vs;
  logic              de_fall, vs_rise;
  logic [HCNT_W-1:0] pix_cnt, hact_nxt;
  logic [VCNT_W-1:0] line_cnt, line_nxt;

  // Line closing is resolved combinationally so that a VS rise in the same
  // cycle as a DE fall captures the line that just ended.
  always_comb begin
    de_fall  = de_d & ~de;
    vs_rise  = vs & ~vs_d;
    hact_nxt = hact;
    line_nxt = line_cnt;
    if (de_fall) begin
      if (pix_cnt != '0) hact_nxt = pix_cnt;
      if (line_cnt != '1) line_nxt = line_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      de_d       <= 1'b0;
      vs_d       <= 1'b0;
      seen_vs    <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      hact       <= '0;
      vact       <= '0;
      meas_valid <= 1'b0;
    end else begin
      de_d <= de;
      vs_d <= vs;
      hact <= hact_nxt;
      if (de_fall)
        pix_cnt <= '0;
      else if (ce && de && pix_cnt != '1)
        pix_cnt <= pix_cnt + 1'b1;
      if (vs_rise) begin
        vact     <= line_nxt;
        line_cnt <= '0;
        seen_vs  <= 1'b1;
        // The frame ending at the first VS after reset is partial.
        if (seen_vs) meas_valid <= (line_nxt != '0) && (hact_nxt != '0);
      end else begin
        line_cnt <= line_nxt;
      end
    end
  end

endmodule

// File: rtl/video_mixer_ng.sv
// video_mixer_ng
// Output mixer between the core's native video and the HDMI/VGA stage:
// colour expansion to 8 bits, freeze blanking, ce_pix pulse/divided-clock
// detection, odd-line scanline darkening and a two-stage output register.
// Optional measurement unit enabled by defining VMIX_MEASURE_EN; otherwise
// hact, vact and meas_valid are tied to 0.
//   CLK_VIDEO, reset          : video clock, synchronous active-high reset
//   ce_pix                    : input pixel enable pulse or divided pixel clock
//   R, G, B                   : input colour, COLOR_W bits each
//   HSync, VSync, HBlank, VBlank : positive sync/blank inputs
//   freeze                    : asynchronous colour-freeze request
//   scanlines                 : odd-line brightness (0 off, 1 75%, 2 50%, 3 25%)
//   CE_PIXEL                  : output pixel enable
//   VGA_R/G/B, VGA_HS/VS/DE   : registered output video
//   hact, vact, meas_valid    : measured active area
module video_mixer_ng
  import video_mixer_ng_pkg::*;
#(
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned HCNT_W  = 12,
  parameter int unsigned VCNT_W  = 11
) (
  input  logic               CLK_VIDEO,
  input  logic               reset,
  input  logic               ce_pix,
  input  logic [COLOR_W-1:0] R,
  input  logic [COLOR_W-1:0] G,
  input  logic [COLOR_W-1:0] B,
  input  logic               HSync,
  input  logic               VSync,
  input  logic               HBlank,
  input  logic               VBlank,
  input  logic               freeze,
  input  logic [1:0]         scanlines,
  output logic               CE_PIXEL,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_DE,
  output logic [HCNT_W-1:0]  hact,
  output logic [VCNT_W-1:0]  vact,
  output logic               meas_valid
);

  logic           frz_m, frz;
  logic           ce_d, ce_osc, fs_osc;
  logic           hs_in_d, vs_in_d, parity;
  logic [7:0]     r1, g1, b1;
  logic           hs1, vs1, vs1_d, hde1, vde1;
  logic           old_hde;
  logic [7:0]     r_x, g_x, b_x;
  scanline_mode_t mode;

  always_comb begin
    mode = parity ? scanline_mode_t'(scanlines) : SL_OFF;
    r_x  = frz ? '0 : sl_scale(expand8(8'(R), COLOR_W), mode);
    g_x  = frz ? '0 : sl_scale(expand8(8'(G), COLOR_W), mode);
    b_x  = frz ? '0 : sl_scale(expand8(8'(B), COLOR_W), mode);
  end

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      frz_m    <= 1'b0;
      frz      <= 1'b0;
      ce_d     <= 1'b0;
      ce_osc   <= 1'b0;
      fs_osc   <= 1'b0;
      CE_PIXEL <= 1'b0;
      hs_in_d  <= 1'b0;
      vs_in_d  <= 1'b0;
      parity   <= 1'b0;
      r1       <= '0;
      g1       <= '0;
      b1       <= '0;
      hs1      <= 1'b0;
      vs1      <= 1'b0;
      vs1_d    <= 1'b0;
      hde1     <= 1'b0;
      vde1     <= 1'b0;
      old_hde  <= 1'b0;
      VGA_R    <= '0;
      VGA_G    <= '0;
      VGA_B    <= '0;
      VGA_HS   <= 1'b0;
      VGA_VS   <= 1'b0;
      VGA_DE   <= 1'b0;
    end else begin
      frz_m <= freeze;
      frz   <= frz_m;

      // Any toggle of ce_pix during a frame marks it as oscillating; the
      // classification is latched once per frame at the stage-1 vs edge.
      ce_d  <= ce_pix;
      vs1_d <= vs1;
      if (vs1 && !vs1_d) begin
        fs_osc <= ce_osc;
        ce_osc <= 1'b0;
      end else if (ce_pix != ce_d) begin
        ce_osc <= 1'b1;
      end
      CE_PIXEL <= fs_osc ? (ce_pix & ~ce_d) : ce_pix;

      hs_in_d <= HSync;
      vs_in_d <= VSync;
      if (VSync && !vs_in_d)
        parity <= 1'b0;
      else if (HSync && !hs_in_d)
        parity <= ~parity;

      r1   <= r_x;
      g1   <= g_x;
      b1   <= b_x;
      hs1  <= HSync;
      vs1  <= VSync;
      hde1 <= ~HBlank;
      vde1 <= ~VBlank;

      if (CE_PIXEL) begin
        VGA_R   <= r1;
        VGA_G   <= g1;
        VGA_B   <= b1;
        VGA_HS  <= hs1;
        VGA_VS  <= vs1;
        old_hde <= hde1;
        // DE only changes on horizontal transitions, so a VBlank edge
        // mid-line never cuts a line short.
        if (hde1 != old_hde) VGA_DE <= vde1 & hde1;
      end
    end
  end

`ifdef VMIX_MEASURE_EN
  vmix_measure #(
    .HCNT_W (HCNT_W),
    .VCNT_W (VCNT_W)
  ) u_measure (
    .CLK_VIDEO  (CLK_VIDEO),
    .reset      (reset),
    .ce         (CE_PIXEL),
    .de         (VGA_DE),
    .vs         (VGA_VS),
    .hact       (hact),
    .vact       (vact),
    .meas_valid (meas_valid)
  );
`else
  assign hact       = '0;
  assign vact       = '0;
  assign meas_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_mixer_ng.sv
module tb_video_mixer_ng;

  logic CLK_VIDEO = 1'b0;
  always #5 CLK_VIDEO = ~CLK_VIDEO;

  logic       reset, ce_pix, HSync, VSync, HBlank, VBlank, freeze;
  logic [1:0] scanlines;
  logic [4:0] ra, ga, ba;
  logic [7:0] rb, gb, bb;

  logic        a_ce, a_hs, a_vs, a_de, a_mv;
  logic [7:0]  a_r, a_g, a_b;
  logic [11:0] a_hact;
  logic [10:0] a_vact;
  logic        b_ce, b_hs, b_vs, b_de, b_mv;
  logic [7:0]  b_r, b_g, b_b;
  logic [11:0] b_hact;
  logic [10:0] b_vact;
  logic        c_ce, c_hs, c_vs, c_de, c_mv;
  logic [7:0]  c_r, c_g, c_b;
  logic [3:0]  c_hact;
  logic [10:0] c_vact;

  video_mixer_ng #(.COLOR_W(5)) dut_a (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ce_pix(ce_pix),
    .R(ra), .G(ga), .B(ba),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .freeze(freeze), .scanlines(scanlines),
    .CE_PIXEL(a_ce), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_DE(a_de),
    .hact(a_hact), .vact(a_vact), .meas_valid(a_mv));

  video_mixer_ng #(.COLOR_W(8)) dut_b (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ce_pix(ce_pix),
    .R(rb), .G(gb), .B(bb),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .freeze(freeze), .scanlines(scanlines),
    .CE_PIXEL(b_ce), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_DE(b_de),
    .hact(b_hact), .vact(b_vact), .meas_valid(b_mv));

  video_mixer_ng #(.COLOR_W(8), .HCNT_W(4)) dut_c (
    .CLK_VIDEO(CLK_VIDEO), .reset(reset), .ce_pix(ce_pix),
    .R(rb), .G(gb), .B(bb),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .freeze(freeze), .scanlines(scanlines),
    .CE_PIXEL(c_ce), .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b),
    .VGA_HS(c_hs), .VGA_VS(c_vs), .VGA_DE(c_de),
    .hact(c_hact), .vact(c_vact), .meas_valid(c_mv));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expansion of a 5-bit value is the value followed by its
  // top three bits; scanline modes are fractions of the channel value.
  function automatic int exp5(input logic [4:0] v);
    return (int'(v) << 3) | (int'(v) >> 2);
  endfunction

  function automatic int scale(input int c, input logic [1:0] mode, input bit odd);
    if (!odd || mode == 2'd0) return c;
    case (mode)
      2'd1:    return c - c / 4;
      2'd2:    return c / 2;
      default: return c / 4;
    endcase
  endfunction

  // Model state: line parity, previous-pixel freeze, horizontal DE tracking.
  bit m_parity, m_hs_prev, m_vs_prev, m_frz_prev, m_hde_prev, m_de;

  task automatic model_reset();
    m_parity = 0; m_hs_prev = 0; m_vs_prev = 0;
    m_frz_prev = 0; m_hde_prev = 0; m_de = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK_VIDEO);
    reset = 1'b1;
    repeat (2) @(negedge CLK_VIDEO);
    reset = 1'b0;
    model_reset();
  endtask

  // One pixel of 4 clocks with a single-clock ce_pix pulse; outputs are
  // checked once the output stage has taken this pixel.
  task automatic pix(input bit hs, input bit vs, input bit hb, input bit vb,
                     input logic [4:0] r5, input logic [4:0] g5, input logic [4:0] b5,
                     input logic [7:0] r8, input logic [7:0] g8, input logic [7:0] b8,
                     input logic [1:0] sl, input bit fz);
    int era, ega, eba, erb, egb, ebb;
    bit odd, fr;
    HSync = hs; VSync = vs; HBlank = hb; VBlank = vb;
    ra = r5; ga = g5; ba = b5; rb = r8; gb = g8; bb = b8;
    scanlines = sl; freeze = fz; ce_pix = 1'b1;
    odd = m_parity;
    fr  = m_frz_prev;
    era = fr ? 0 : scale(exp5(r5), sl, odd);
    ega = fr ? 0 : scale(exp5(g5), sl, odd);
    eba = fr ? 0 : scale(exp5(b5), sl, odd);
    erb = fr ? 0 : scale(int'(r8), sl, odd);
    egb = fr ? 0 : scale(int'(g8), sl, odd);
    ebb = fr ? 0 : scale(int'(b8), sl, odd);
    if (vs && !m_vs_prev) m_parity = 0;
    else if (hs && !m_hs_prev) m_parity = !m_parity;
    m_vs_prev = vs; m_hs_prev = hs; m_frz_prev = fz;
    if (!hb != m_hde_prev) m_de = !vb && !hb;
    m_hde_prev = !hb;
    @(negedge CLK_VIDEO);
    ce_pix = 1'b0;
    @(negedge CLK_VIDEO);
    chk("A.VGA_R", 32'(a_r), era);
    chk("A.VGA_G", 32'(a_g), ega);
    chk("A.VGA_B", 32'(a_b), eba);
    chk("B.VGA_R", 32'(b_r), erb);
    chk("B.VGA_G", 32'(b_g), egb);
    chk("B.VGA_B", 32'(b_b), ebb);
    chk("C.VGA_R", 32'(c_r), erb);
    chk("B.VGA_HS", 32'(b_hs), 32'(hs));
    chk("B.VGA_VS", 32'(b_vs), 32'(vs));
    chk("B.VGA_DE", 32'(b_de), 32'(m_de));
    chk("A.VGA_DE", 32'(a_de), 32'(m_de));
    repeat (2) @(negedge CLK_VIDEO);
  endtask

  typedef struct {
    logic [4:0] r5, g5, b5;
    logic [7:0] r8;
    logic [1:0] sl;
    bit         odd;
    logic [7:0] ea_r, ea_g, ea_b, eb_r;
  } vec_t;

  vec_t tbl[7];
  bit   ch[0:63];
  int   hi;
  bit   frzv;

  initial begin
    tbl[0] = '{5'b10110, 5'h00, 5'h1F, 8'hC8, 2'd0, 1'b0, 8'hB5, 8'h00, 8'hFF, 8'hC8};
    tbl[1] = '{5'b10110, 5'h00, 5'h1F, 8'hC8, 2'd2, 1'b0, 8'hB5, 8'h00, 8'hFF, 8'hC8};
    tbl[2] = '{5'b10110, 5'h00, 5'h1F, 8'hC8, 2'd2, 1'b1, 8'h5A, 8'h00, 8'h7F, 8'h64};
    tbl[3] = '{5'b10110, 5'h00, 5'h1F, 8'hC8, 2'd1, 1'b1, 8'h88, 8'h00, 8'hC0, 8'h96};
    tbl[4] = '{5'b10110, 5'h00, 5'h1F, 8'hC8, 2'd3, 1'b1, 8'h2D, 8'h00, 8'h3F, 8'h32};
    tbl[5] = '{5'b00001, 5'b10000, 5'b01010, 8'h01, 2'd3, 1'b1, 8'h02, 8'h21, 8'h14, 8'h00};
    tbl[6] = '{5'b00001, 5'b10000, 5'b01010, 8'hC8, 2'd0, 1'b1, 8'h08, 8'h84, 8'h52, 8'hC8};

    // Reset with every input active: all outputs must read 0.
    reset = 1'b1; ce_pix = 1'b1; HSync = 1'b1; VSync = 1'b1; HBlank = 1'b0;
    VBlank = 1'b0; freeze = 1'b0; scanlines = 2'd0;
    ra = 5'h1F; ga = 5'h1F; ba = 5'h1F; rb = 8'hFF; gb = 8'hFF; bb = 8'hFF;
    repeat (4) @(negedge CLK_VIDEO);
    chk("reset.A", 32'({a_ce, a_r, a_g, a_b, a_hs, a_vs, a_de}), 0);
    chk("reset.B", 32'({b_ce, b_r, b_g, b_b, b_hs, b_vs, b_de}), 0);
    chk("reset.C", 32'({c_ce, c_r, c_g, c_b, c_hs, c_vs, c_de}), 0);
    chk("reset.meas", 32'({b_hact, b_vact, b_mv, c_hact, c_mv}), 0);
    ce_pix = 1'b0; HSync = 1'b0; VSync = 1'b0; HBlank = 1'b1; VBlank = 1'b1;
    do_reset();

    // Divided clock (2 high / 2 low): passed through delayed until the
    // first stage-1 vs edge, then reduced to its rising-edge pulses.
    hi = 0;
    for (int k = 0; k < 38; k++) begin
      if (k >= 1 && k <= 16) begin
        chk("ce.div.A", 32'(a_ce), 32'(ch[k-1]));
        chk("ce.div.B", 32'(b_ce), 32'(ch[k-1]));
        hi += int'(b_ce);
      end
      if (k == 17) begin
        chk("ce.div.count", 32'(hi), 8);
        hi = 0;
        VSync = 1'b1;
      end
      if (k >= 22) begin
        chk("ce.pulse.B", 32'(b_ce), 32'(ch[k-1] & ~ch[k-2]));
        hi += int'(b_ce);
      end
      ch[k] = (k % 4) < 2;
      ce_pix = ch[k];
      @(negedge CLK_VIDEO);
    end
    chk("ce.pulse.count", 32'(hi), 4);
    ce_pix = 1'b0; VSync = 1'b0;
    do_reset();

    // Expansion and scanline table; parity is set up with sync pulses.
    for (int i = 0; i < 7; i++) begin
      pix(0, 1, 1, 1, 5'h0, 5'h0, 5'h0, 8'h0, 8'h0, 8'h0, 2'd0, 0);
      pix(0, 0, 1, 1, 5'h0, 5'h0, 5'h0, 8'h0, 8'h0, 8'h0, 2'd0, 0);
      if (tbl[i].odd) begin
        pix(1, 0, 1, 0, 5'h0, 5'h0, 5'h0, 8'h0, 8'h0, 8'h0, 2'd0, 0);
        pix(0, 0, 1, 0, 5'h0, 5'h0, 5'h0, 8'h0, 8'h0, 8'h0, 2'd0, 0);
      end
      pix(0, 0, 0, 0, tbl[i].r5, tbl[i].g5, tbl[i].b5, tbl[i].r8, 8'h00, 8'h00, tbl[i].sl, 0);
      chk("tbl.A.R", 32'(a_r), 32'(tbl[i].ea_r));
      chk("tbl.A.G", 32'(a_g), 32'(tbl[i].ea_g));
      chk("tbl.A.B", 32'(a_b), 32'(tbl[i].ea_b));
      chk("tbl.B.R", 32'(b_r), 32'(tbl[i].eb_r));
    end

    // Random frames: 20x12 active in 28x15 total, reset in mid-frame 0.
    frzv = 0;
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 15; l++) begin
        for (int x = 0; x < 28; x++) begin
          if (f == 0 && l == 5 && x == 10) do_reset();
          if ($urandom_range(0, 15) == 0) frzv = !frzv;
          pix(x >= 22 && x < 25, l == 13, x >= 20, l >= 12,
              5'($urandom), 5'($urandom), 5'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom),
              2'($urandom_range(0, 3)), frzv);
          if (l == 13 && x == 4) begin
`ifdef VMIX_MEASURE_EN
            if (f == 0) begin
              chk("meas.first.B.valid", 32'(b_mv), 0);
              chk("meas.first.C.valid", 32'(c_mv), 0);
              chk("meas.first.B.vact", 32'(b_vact), 7);
            end else begin
              chk("meas.B.hact", 32'(b_hact), 20);
              chk("meas.B.vact", 32'(b_vact), 12);
              chk("meas.B.valid", 32'(b_mv), 1);
              chk("meas.C.hact_sat", 32'(c_hact), 15);
              chk("meas.C.vact", 32'(c_vact), 12);
              chk("meas.C.valid", 32'(c_mv), 1);
            end
`else
            chk("meas.off.B", 32'({b_hact, b_vact, b_mv}), 0);
            chk("meas.off.C", 32'({c_hact, c_vact, c_mv}), 0);
`endif
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
